confusion_accumulator: RTL and testbench
========================================

Name: confusion_accumulator

Overview:
- Hardware replacement for the testbench-side confusion-matrix bookkeeping of a column.
- Accumulates (winner neuron, true label) pairs from each classified image into a NEURONS x CLASSES matrix of saturating counters, plus image and spike totals.
- On command, scans the matrix to form the purity numerator (sum of per-neuron row maxima), then streams every cell out over a valid/ready port.
- Sits beside the column, driven by its valid/no_winner/winner outputs and a label stream.

Parameters:
- NEURONS, 12, neurons per column (matrix rows).
- CLASSES, 10, label classes (matrix columns).
- COUNT_W, 16, width of each matrix cell counter.
- TOTAL_W, 32, width of the image, spike and dropped counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- clear  in  1  synchronous zeroing of all counters; returns FSM to ACCUM.
- in_valid  in  1  one classification result this cycle.
- no_winner  in  1  qualifies in_valid: image produced no spike.
- winner  in  $clog2(NEURONS)  winning neuron index.
- label  in  $clog2(CLASSES)  true class of the image.
- finish  in  1  pulse: end accumulation, start SCAN.
- busy  out  1  high in SCAN or DUMP.
- images  out  TOTAL_W  count of in_valid events accepted.
- spikes  out  TOTAL_W  accepted events with a winner and a legal label.
- dropped  out  TOTAL_W  in_valid events received outside ACCUM.
- purity_num  out  COUNT_W+$clog2(NEURONS)  sum of row maxima; valid when stats_valid.
- stats_valid  out  1  high in DONE.
- rd_valid  out  1  cell available.
- rd_ready  in  1  consumer accepts cell.
- rd_neuron  out  $clog2(NEURONS)  row of current cell.
- rd_class  out  $clog2(CLASSES)  column of current cell.
- rd_count  out  COUNT_W  cell value.
- rd_last  out  1  final cell (NEURONS-1, CLASSES-1).

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM to ACCUM.
  - All cells, images, spikes, dropped, purity_num cleared to 0.
  - busy, stats_valid, rd_valid, rd_last = 0; rd_neuron, rd_class, rd_count = 0.
- Reset or clear mid-SCAN/DUMP aborts immediately with the same result as reset. Reset has priority over clear; clear has priority over any event in the same cycle.
- FSM states: ACCUM -> SCAN (finish) -> DUMP (scan complete) -> DONE (last cell handshaken) -> ACCUM (clear only).
- ACCUM, in_valid=1:
  - images += 1.
  - If no_winner=0 and label<CLASSES and winner<NEURONS: spikes += 1 and cell[winner][label] += 1, visible the next cycle.
  - Illegal indices count only toward images.
- Outside ACCUM, in_valid increments dropped only; the matrix and the other totals are unchanged.
- All counters saturate at their all-ones value; no wrap.
- finish and in_valid in the same ACCUM cycle: the event is accumulated, then SCAN begins. finish outside ACCUM is ignored.
- SCAN:
  - One cell per cycle, row-major; NEURONS*CLASSES cycles total.
  - Running row maximum is reset at the start of each row; on the row's last cell, max(row) is added to purity_num.
  - purity_num is cleared on entry to SCAN.
- DUMP:
  - Cells are presented row-major from (0,0).
  - rd_valid stays high, and rd_neuron/rd_class/rd_count/rd_last stay stable, until rd_ready=1. The index advances on the handshake cycle.
  - Back-to-back transfers give one cell per cycle with rd_ready held high.
  - rd_last=1 only with cell (NEURONS-1, CLASSES-1). Its handshake moves to DONE, and rd_valid drops the next cycle.
- DONE: stats_valid=1; totals and matrix held; busy=0.
- Accuracy is computed by software as purity_num/spikes and spikes/images; no divider is included.

Test Plan:
- Reset, then 5 in_valid with winner=3 label=7, one with no_winner=1 -> images=6, spikes=5; after finish, DUMP cell(3,7)=5 and all other cells 0; purity_num=5.
- Row 0 gets {label2:4, label5:4, label9:1}; row 1 gets {label1:2} -> purity_num=6 (tie takes value 4 once); spikes=11.
- 70000 events to cell (0,0) with COUNT_W=16 -> cell(0,0)=65535 and stays there; spikes=70000.
- in_valid asserted 3 times during SCAN and 2 during DUMP -> dropped=5; images, spikes and cells unchanged.
- DUMP with rd_ready toggling 1,0,0,1 -> rd_count/rd_neuron/rd_class hold while stalled; 120 handshakes total; rd_last only on (11,9); stats_valid=1 the cycle after.
- clear asserted mid-DUMP with a simultaneous in_valid -> next cycle in ACCUM, all counters 0, rd_valid=0, event not counted.

Source files
------------

// File: rtl/confusion_accumulator_if.sv
`default_nettype none
// ============================================================================
// confusion_accumulator_if : cell read-out stream (valid/ready) of the
//                            confusion accumulator
// Revision: 1.0
// ============================================================================
interface confusion_accumulator_if #(
  parameter int NEURONS = 12,
  parameter int CLASSES = 10,
  parameter int COUNT_W = 16
);
  logic                       rd_valid;
  logic                       rd_ready;
  logic [$clog2(NEURONS)-1:0] rd_neuron;
  logic [$clog2(CLASSES)-1:0] rd_class;
  logic [COUNT_W-1:0]         rd_count;
  logic                       rd_last;

  modport master (
    output rd_valid, rd_neuron, rd_class, rd_count, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_neuron, rd_class, rd_count, rd_last,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/confusion_accumulator.sv
`default_nettype none
// ============================================================================
// confusion_accumulator : saturating NEURONS x CLASSES confusion matrix with
//                         purity scan and streamed cell dump
// Revision: 1.0
// ============================================================================
module confusion_accumulator #(
  parameter int NEURONS = 12,
  parameter int CLASSES = 10,
  parameter int COUNT_W = 16,
  parameter int TOTAL_W = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic                                 no_winner,
  input  logic [$clog2(NEURONS)-1:0]           winner,
  input  logic [$clog2(CLASSES)-1:0]           label,
  input  logic                                 finish,
  output logic                                 busy,
  output logic [TOTAL_W-1:0]                   images,
  output logic [TOTAL_W-1:0]                   spikes,
  output logic [TOTAL_W-1:0]                   dropped,
  output logic [COUNT_W+$clog2(NEURONS)-1:0]   purity_num,
  output logic                                 stats_valid,
  confusion_accumulator_if.master              rd
);

  localparam int c_NW    = $clog2(NEURONS);
  localparam int c_CW    = $clog2(CLASSES);
  localparam int c_PW    = COUNT_W + c_NW;
  localparam int c_CELLS = NEURONS * CLASSES;
  localparam int c_IDX_W = $clog2(c_CELLS);
  localparam logic [c_NW-1:0]    c_LAST_ROW  = c_NW'(NEURONS - 1);
  localparam logic [c_CW-1:0]    c_LAST_COL  = c_CW'(CLASSES - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_CELL = c_IDX_W'(c_CELLS - 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_DUMP, ST_DONE} state_t;

  state_t               state_q;
  logic [COUNT_W-1:0]   cells_q [c_CELLS];
  logic [TOTAL_W-1:0]   images_q, spikes_q, dropped_q;
  logic [c_PW-1:0]      purity_q;
  logic [COUNT_W-1:0]   row_max_q;
  logic [c_IDX_W-1:0]   ptr_q;
  logic [c_NW-1:0]      row_q;
  logic [c_CW-1:0]      col_q;
  logic                 rd_valid_q, rd_last_q;
  logic [COUNT_W-1:0]   rd_count_q;

  logic                 legal_d;
  logic [c_IDX_W-1:0]   in_idx_d;
  logic [COUNT_W-1:0]   cell_cur_d, scan_max_d;
  logic                 row_end_d, last_cell_d;
  logic [c_IDX_W-1:0]   ptr_d;
  logic [c_NW-1:0]      row_d;
  logic [c_CW-1:0]      col_d;

  function automatic logic [TOTAL_W-1:0] sat_total(input logic [TOTAL_W-1:0] x);
    return (&x) ? x : x + TOTAL_W'(1);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_cell(input logic [COUNT_W-1:0] x);
    return (&x) ? x : x + COUNT_W'(1);
  endfunction

  assign legal_d     = !no_winner && (winner <= c_LAST_ROW) && (label <= c_LAST_COL);
  assign in_idx_d    = c_IDX_W'(winner) * c_IDX_W'(CLASSES) + c_IDX_W'(label);
  assign cell_cur_d  = cells_q[ptr_q];
  // The row maximum restarts on each row's first column.
  assign scan_max_d  = ((col_q == '0) || (cell_cur_d > row_max_q)) ? cell_cur_d : row_max_q;
  assign row_end_d   = (col_q == c_LAST_COL);
  assign last_cell_d = row_end_d && (row_q == c_LAST_ROW);
  assign ptr_d       = ptr_q + c_IDX_W'(1);
  assign row_d       = row_end_d ? row_q + c_NW'(1) : row_q;
  assign col_d       = row_end_d ? '0 : col_q + c_CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q    <= ST_ACCUM;
      for (int i = 0; i < c_CELLS; i++) cells_q[i] <= '0;
      images_q   <= '0;
      spikes_q   <= '0;
      dropped_q  <= '0;
      purity_q   <= '0;
      row_max_q  <= '0;
      ptr_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            images_q <= sat_total(images_q);
            if (legal_d) begin
              spikes_q          <= sat_total(spikes_q);
              cells_q[in_idx_d] <= sat_cell(cells_q[in_idx_d]);
            end
          end
          if (finish) begin
            state_q  <= ST_SCAN;
            purity_q <= '0;
            ptr_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
          end
        end
        ST_SCAN: begin
          row_max_q <= scan_max_d;
          if (row_end_d) purity_q <= purity_q + c_PW'(scan_max_d);
          if (last_cell_d) begin
            state_q    <= ST_DUMP;
            ptr_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rd_valid_q <= 1'b1;
            rd_count_q <= cells_q[0];
            rd_last_q  <= (c_CELLS == 1);
          end else begin
            ptr_q <= ptr_d;
            row_q <= row_d;
            col_q <= col_d;
          end
        end
        ST_DUMP: begin
          if (rd.rd_ready) begin
            if (rd_last_q) begin
              state_q    <= ST_DONE;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
            end else begin
              ptr_q      <= ptr_d;
              row_q      <= row_d;
              col_q      <= col_d;
              rd_count_q <= cells_q[ptr_d];
              rd_last_q  <= (ptr_d == c_LAST_CELL);
            end
          end
        end
        ST_DONE: begin
        end
      endcase
      if (in_valid && (state_q != ST_ACCUM)) dropped_q <= sat_total(dropped_q);
    end
  end

  assign busy         = (state_q == ST_SCAN) || (state_q == ST_DUMP);
  assign stats_valid  = (state_q == ST_DONE);
  assign images       = images_q;
  assign spikes       = spikes_q;
  assign dropped      = dropped_q;
  assign purity_num   = purity_q;
  assign rd.rd_valid  = rd_valid_q;
  assign rd.rd_neuron = row_q;
  assign rd.rd_class  = col_q;
  assign rd.rd_count  = rd_count_q;
  assign rd.rd_last   = rd_last_q;

endmodule
`default_nettype wire

// File: tb/tb_confusion_accumulator.sv
`default_nettype none
// ============================================================================
// tb_confusion_accumulator : self-checking bench with a matrix-level model
// Revision: 1.0
// ============================================================================
module tb_confusion_accumulator;
  localparam int NEURONS = 12;
  localparam int CLASSES = 10;
  localparam int COUNT_W = 16;
  localparam int TOTAL_W = 32;
  localparam int NW      = $clog2(NEURONS);
  localparam int CW      = $clog2(CLASSES);
  localparam int PW      = COUNT_W + NW;
  localparam int CELLS   = NEURONS * CLASSES;
  localparam longint CMAX = (longint'(1) << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, no_winner, finish;
  logic [NW-1:0] winner;
  logic [CW-1:0] label;
  logic busy, stats_valid;
  logic [TOTAL_W-1:0] images, spikes, dropped;
  logic [PW-1:0] purity_num;

  confusion_accumulator_if #(.NEURONS(NEURONS), .CLASSES(CLASSES), .COUNT_W(COUNT_W)) rd_if ();

  confusion_accumulator #(
    .NEURONS(NEURONS), .CLASSES(CLASSES), .COUNT_W(COUNT_W), .TOTAL_W(TOTAL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .no_winner(no_winner), .winner(winner), .label(label), .finish(finish),
    .busy(busy), .images(images), .spikes(spikes), .dropped(dropped),
    .purity_num(purity_num), .stats_valid(stats_valid), .rd(rd_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint m_cells [NEURONS][CLASSES];
  longint m_images, m_spikes, m_dropped;

  task automatic model_clear();
    for (int r = 0; r < NEURONS; r++)
      for (int c = 0; c < CLASSES; c++) m_cells[r][c] = 0;
    m_images = 0; m_spikes = 0; m_dropped = 0;
  endtask

  task automatic model_event(input int w, input int l, input bit nw);
    m_images++;
    if (!nw && w < NEURONS && l < CLASSES) begin
      m_spikes++;
      if (m_cells[w][l] < CMAX) m_cells[w][l]++;
    end
  endtask

  function automatic longint model_purity();
    longint sum = 0;
    for (int r = 0; r < NEURONS; r++) begin
      longint mx = 0;
      for (int c = 0; c < CLASSES; c++) if (m_cells[r][c] > mx) mx = m_cells[r][c];
      sum += mx;
    end
    return sum;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; the model is updated by the caller.
  task automatic drive(input bit v, input int w, input int l, input bit nw, input bit fin);
    in_valid = v; winner = NW'(w); label = CW'(l); no_winner = nw; finish = fin;
    step();
    in_valid = 0; finish = 0; no_winner = 0;
  endtask

  task automatic send_event(input int w, input int l, input bit nw, input bit fin);
    model_event(w, l, nw);
    drive(1'b1, w, l, nw, fin);
  endtask

  task automatic do_clear();
    clear = 1; step(); clear = 0;
    model_clear();
  endtask

  task automatic wait_rd_valid(input string tag);
    int cyc = 0;
    while (rd_if.rd_valid !== 1'b1 && cyc < CELLS + 20) begin step(); cyc++; end
    checks++;
    if (rd_if.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_rd_valid got %b expected 1 within %0d cycles", tag, rd_if.rd_valid, CELLS + 20);
    end
  endtask

  // Drains the dump (mode 0: ready held, 1: ready 1,0,0,1 pattern, 2: random) and checks DONE.
  task automatic run_dump(input int mode, input string tag);
    int k = 0;
    int cyc = 0;
    int r, c;
    bit rdy;
    wait_rd_valid(tag);
    while (k < CELLS && cyc < 6 * CELLS) begin
      r = k / CLASSES; c = k % CLASSES;
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_neuron !== NW'(r) || rd_if.rd_class !== CW'(c) ||
          rd_if.rd_count !== COUNT_W'(m_cells[r][c]) || rd_if.rd_last !== (k == CELLS - 1)) begin
        errors++;
        $display("FAIL %s_cell k=%0d got v=%b n=%0d c=%0d cnt=%0d last=%b expected v=1 n=%0d c=%0d cnt=%0d last=%b",
                 tag, k, rd_if.rd_valid, rd_if.rd_neuron, rd_if.rd_class, rd_if.rd_count, rd_if.rd_last,
                 r, c, m_cells[r][c], (k == CELLS - 1));
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_if.rd_ready = rdy;
      step();
      cyc++;
      if (rdy) k++;
    end
    rd_if.rd_ready = 1'b0;
    checks++;
    if (k != CELLS) begin
      errors++;
      $display("FAIL %s_handshakes got %0d expected %0d", tag, k, CELLS);
    end
    checks++;
    if (rd_if.rd_valid !== 1'b0 || stats_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got rd_valid=%b stats_valid=%b busy=%b expected 0 1 0", tag, rd_if.rd_valid, stats_valid, busy);
    end
    checks++;
    if (purity_num !== PW'(model_purity())) begin
      errors++;
      $display("FAIL %s_purity got %0d expected %0d", tag, purity_num, model_purity());
    end
    checks++;
    if (images !== TOTAL_W'(m_images) || spikes !== TOTAL_W'(m_spikes) || dropped !== TOTAL_W'(m_dropped)) begin
      errors++;
      $display("FAIL %s_totals got images=%0d spikes=%0d dropped=%0d expected %0d %0d %0d",
               tag, images, spikes, dropped, m_images, m_spikes, m_dropped);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; in_valid = 0; no_winner = 0; finish = 0; winner = '0; label = '0;
    rd_if.rd_ready = 0;
    step(); step();
    rst_n = 1;
    model_clear();
    checks++;
    if (busy !== 1'b0 || stats_valid !== 1'b0 || rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b stats=%b rd_valid=%b rd_last=%b expected all 0", busy, stats_valid, rd_if.rd_valid, rd_if.rd_last);
    end
    checks++;
    if (images !== '0 || spikes !== '0 || dropped !== '0 || purity_num !== '0) begin
      errors++;
      $display("FAIL reset_totals got %0d %0d %0d %0d expected all 0", images, spikes, dropped, purity_num);
    end
    checks++;
    if (rd_if.rd_neuron !== '0 || rd_if.rd_class !== '0 || rd_if.rd_count !== '0) begin
      errors++;
      $display("FAIL reset_rd got n=%0d c=%0d cnt=%0d expected 0 0 0", rd_if.rd_neuron, rd_if.rd_class, rd_if.rd_count);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) send_event(3, 7, 1'b0, 1'b0);
    send_event(3, 7, 1'b1, 1'b0);
    checks++;
    if (images !== 32'd6 || spikes !== 32'd5) begin
      errors++;
      $display("FAIL basic_totals got images=%0d spikes=%0d expected 6 5", images, spikes);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b expected 1", busy);
    end
    run_dump(0, "basic");
    checks++;
    if (purity_num !== PW'(5)) begin
      errors++;
      $display("FAIL basic_purity5 got %0d expected 5", purity_num);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    step();
    checks++;
    if (busy !== 1'b0 || stats_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_finish_in_done got busy=%b stats=%b expected 0 1", busy, stats_valid);
    end
  endtask

  task automatic test_purity_tie();
    do_clear();
    for (int i = 0; i < 4; i++) send_event(0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_event(0, 5, 1'b0, 1'b0);
    send_event(0, 9, 1'b0, 1'b0);
    send_event(1, 1, 1'b0, 1'b0);
    send_event(1, 1, 1'b0, 1'b1);
    run_dump(0, "purity");
    checks++;
    if (purity_num !== PW'(6) || spikes !== 32'd11) begin
      errors++;
      $display("FAIL purity_tie got purity=%0d spikes=%0d expected 6 11", purity_num, spikes);
    end
  endtask

  task automatic test_dropped_and_stall();
    do_clear();
    send_event(5, 4, 1'b0, 1'b0);
    send_event(11, 9, 1'b0, 1'b0);
    send_event(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin drive(1'b1, 2, 2, 1'b0, 1'b0); m_dropped++; end
    checks++;
    if (busy !== 1'b1 || rd_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_in_scan got busy=%b rd_valid=%b expected 1 0", busy, rd_if.rd_valid);
    end
    wait_rd_valid("dropped");
    for (int i = 0; i < 2; i++) begin drive(1'b1, 5, 4, 1'b0, 1'b0); m_dropped++; end
    run_dump(1, "stall");
    checks++;
    if (dropped !== 32'd5 || images !== 32'd3) begin
      errors++;
      $display("FAIL dropped_count got dropped=%0d images=%0d expected 5 3", dropped, images);
    end
  endtask

  task automatic test_clear_mid_dump();
    do_clear();
    send_event(4, 4, 1'b0, 1'b0);
    send_event(6, 1, 1'b0, 1'b1);
    wait_rd_valid("clear");
    rd_if.rd_ready = 1'b1;
    repeat (5) step();
    rd_if.rd_ready = 1'b0;
    clear = 1;
    drive(1'b1, 1, 1, 1'b0, 1'b0);
    clear = 0;
    model_clear();
    checks++;
    if (busy !== 1'b0 || stats_valid !== 1'b0 || rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags got busy=%b stats=%b rd_valid=%b rd_last=%b expected all 0", busy, stats_valid, rd_if.rd_valid, rd_if.rd_last);
    end
    checks++;
    if (images !== '0 || spikes !== '0 || dropped !== '0 || purity_num !== '0) begin
      errors++;
      $display("FAIL clear_totals got %0d %0d %0d %0d expected all 0", images, spikes, dropped, purity_num);
    end
    send_event(2, 4, 1'b0, 1'b0);
    checks++;
    if (images !== 32'd1 || spikes !== 32'd1) begin
      errors++;
      $display("FAIL clear_accum got images=%0d spikes=%0d expected 1 1", images, spikes);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    run_dump(0, "clear");
  endtask

  task automatic test_random();
    int n = 300;
    do_clear();
    for (int i = 0; i < n; i++) begin
      int w = $urandom_range(0, 15);
      int l = $urandom_range(0, 15);
      bit nw = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) drive(1'b0, 0, 0, 1'b0, 1'b0);
      if (($urandom_range(0, 2) != 0) && w < NEURONS && l < CLASSES) begin
        w = $urandom_range(0, 3); l = $urandom_range(0, 3);
      end
      send_event(w, l, nw, (i == n - 1));
    end
    run_dump(2, "random");
  endtask

  task automatic test_saturation();
    do_clear();
    in_valid = 1; winner = '0; label = '0; no_winner = 0;
    for (int i = 0; i < 70000; i++) begin
      model_event(0, 0, 1'b0);
      step();
    end
    in_valid = 0;
    checks++;
    if (spikes !== 32'd70000) begin
      errors++;
      $display("FAIL sat_spikes got %0d expected 70000", spikes);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_rd_valid("sat");
    checks++;
    if (rd_if.rd_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_cell00 got %0d expected 65535", rd_if.rd_count);
    end
    run_dump(0, "sat");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_purity_tie();
    test_dropped_and_stall();
    test_clear_mid_dump();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
